i2s_transmitter: RTL and testbench



---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_transmitter_if.sv | 27 ++
 rtl/i2s_tx_shifter.sv | 47 ++++
 rtl/i2s_transmitter.sv | 119 +++++++++++
 tb/tb_i2s_transmitter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and state encoding for the I2S transmitter.
package i2s_pkg;

  localparam int DEFAULT_DATA_WIDTH = 24;
  localparam int DEFAULT_SLOT_WIDTH = 32;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } tx_state_e;

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample-pair handshake between the processing path and the I2S transmitter.
interface i2s_transmitter_if
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] i_audio_left;
  logic [DATA_WIDTH-1:0] i_audio_right;
  logic                  i_audio_valid;
  logic                  o_audio_ready;

  modport master (
    output i_audio_left,
    output i_audio_right,
    output i_audio_valid,
    input  o_audio_ready
  );

  modport slave (
    input  i_audio_left,
    input  i_audio_right,
    input  i_audio_valid,
    output o_audio_ready
  );

endinterface

// File: rtl/i2s_tx_shifter.sv
// MSB-first slot shifter: load presents data_i's MSB this cycle, then shifts until
// DATA_WIDTH bits have gone out and raises done_o.
module i2s_tx_shifter #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  bclk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  shift_out_o,
  output logic                  done_o
);

  localparam int CNT_W = $clog2(SLOT_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign shift_out_o = shift_q[DATA_WIDTH-1];
  assign done_o      = (cnt_q == CNT_LAST);

  // The MSB leaves through the caller on the load cycle, so the register keeps the rest.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = data_i << 1;
      cnt_d   = CNT_W'(1);
    end else if (!done_o) begin
      shift_d = shift_q << 1;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S slave transmitter on codec bclk/lrclk with a one-pair holding buffer.
// Define I2S_TX_UNDERRUN_REPEAT_EN to resend the last pair on underrun instead of zeros.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SLOT_WIDTH = DEFAULT_SLOT_WIDTH
) (
  input  logic               bclk,
  input  logic               reset,
  input  logic               lrclk,
  i2s_transmitter_if.slave   audio,
  output logic               sdata_out,
  output logic               o_underrun
);

  tx_state_e             state_q, state_d;
  logic                  lrclk_q;
  logic                  frame_start, right_start, accept;
  logic                  buf_full_q;
  logic [DATA_WIDTH-1:0] buf_left_q, buf_right_q;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic [DATA_WIDTH-1:0] fill_left, fill_right;
  logic                  sdata_q, sdata_d, underrun_q;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  shift_out, done;

  assign frame_start         = (lrclk_q == CH_RIGHT) && (lrclk == CH_LEFT);
  assign right_start         = (lrclk_q == CH_LEFT) && (lrclk == CH_RIGHT);
  assign accept              = audio.i_audio_valid && audio.o_audio_ready;
  assign audio.o_audio_ready = ~buf_full_q;
  assign sdata_out           = sdata_q;
  assign o_underrun          = underrun_q;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [DATA_WIDTH-1:0] last_left_q, last_right_q;

  always_ff @(posedge bclk) begin
    if (reset) begin
      last_left_q  <= '0;
      last_right_q <= '0;
    end else if (frame_start && buf_full_q) begin
      last_left_q  <= buf_left_q;
      last_right_q <= buf_right_q;
    end
  end

  assign fill_left  = last_left_q;
  assign fill_right = last_right_q;
`else
  assign fill_left  = '0;
  assign fill_right = '0;
`endif

  i2s_tx_shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .SLOT_WIDTH(SLOT_WIDTH)
  ) u_shifter (
    .bclk       (bclk),
    .reset      (reset),
    .load_i     (load),
    .data_i     (load_data),
    .shift_out_o(shift_out),
    .done_o     (done)
  );

  // Any lrclk edge restarts a slot immediately, which also truncates a short slot.
  always_comb begin
    state_d   = state_q;
    right_d   = right_q;
    load      = 1'b0;
    load_data = '0;
    sdata_d   = 1'b0;
    if (frame_start) begin
      state_d   = LEFT;
      load      = 1'b1;
      load_data = buf_full_q ? buf_left_q : fill_left;
      right_d   = buf_full_q ? buf_right_q : fill_right;
    end else if (right_start && (state_q != IDLE)) begin
      state_d   = RIGHT;
      load      = 1'b1;
      load_data = right_q;
    end
    if (load) begin
      sdata_d = load_data[DATA_WIDTH-1];
    end else if ((state_q != IDLE) && !done) begin
      sdata_d = shift_out;
    end
  end

  // The frame load sees the buffer before this cycle's acceptance.
  always_ff @(posedge bclk) begin
    if (reset) begin
      state_q     <= IDLE;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
      right_q     <= '0;
      buf_full_q  <= 1'b0;
      buf_left_q  <= '0;
      buf_right_q <= '0;
    end else begin
      state_q    <= state_d;
      lrclk_q    <= lrclk;
      sdata_q    <= sdata_d;
      underrun_q <= frame_start && !buf_full_q;
      right_q    <= right_d;
      if (accept) begin
        buf_full_q  <= 1'b1;
        buf_left_q  <= audio.i_audio_left;
        buf_right_q <= audio.i_audio_right;
      end else if (frame_start) begin
        buf_full_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: bench-driven lrclk, a slot-level reference
// model checked every bclk, plus directed word captures per scenario.
module tb_i2s_transmitter;
  import i2s_pkg::*;

  localparam int DW = DEFAULT_DATA_WIDTH;
  localparam int SW = DEFAULT_SLOT_WIDTH;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic bclk = 1'b0;
  logic reset;
  logic lrclk;
  logic sdata_out;
  logic o_underrun;

  i2s_transmitter_if #(.DATA_WIDTH(DW)) audio_if ();

  i2s_transmitter #(
    .DATA_WIDTH(DW),
    .SLOT_WIDTH(SW)
  ) dut (
    .bclk      (bclk),
    .reset     (reset),
    .lrclk     (lrclk),
    .audio     (audio_if),
    .sdata_out (sdata_out),
    .o_underrun(o_underrun)
  );

  always #10 bclk = ~bclk;

  int    tests = 0;
  int    fails = 0;
  int    phase = 0;
  string cur_test = "init";

  bit          m_prev, m_armed, m_full;
  logic [DW-1:0] m_buf_l, m_buf_r, m_cur_r, m_last_l, m_last_r, m_word;
  int          m_pos;
  bit          exp_sdata, exp_under;
  bit          last_fs, last_rs, last_acc;

  // One bclk: derive lrclk from the phase counter, advance the slot model, check all outputs.
  task automatic tick();
    bit fs, rs, acc;
    lrclk = ((phase / SW) % 2) == 1;
    phase++;
    last_fs  = 1'b0;
    last_rs  = 1'b0;
    last_acc = 1'b0;
    if (reset) begin
      m_prev   = 1'b0;
      m_armed  = 1'b0;
      m_full   = 1'b0;
      m_last_l = '0;
      m_last_r = '0;
      m_cur_r  = '0;
      m_word   = '0;
      m_pos    = DW;
      exp_sdata = 1'b0;
      exp_under = 1'b0;
    end else begin
      fs  = m_prev && !lrclk;
      rs  = !m_prev && lrclk;
      acc = audio_if.i_audio_valid && !m_full;
      exp_under = 1'b0;
      if (fs) begin
        m_armed = 1'b1;
        if (m_full) begin
          m_word   = m_buf_l;
          m_cur_r  = m_buf_r;
          m_last_l = m_buf_l;
          m_last_r = m_buf_r;
        end else begin
          exp_under = 1'b1;
          m_word  = REPEAT ? m_last_l : '0;
          m_cur_r = REPEAT ? m_last_r : '0;
        end
        m_pos = 0;
      end else if (rs && m_armed) begin
        m_word = m_cur_r;
        m_pos  = 0;
      end else if (m_pos < DW) begin
        m_pos++;
      end
      exp_sdata = (m_armed && (m_pos < DW)) ? m_word[DW-1-m_pos] : 1'b0;
      if (acc) begin
        m_full  = 1'b1;
        m_buf_l = audio_if.i_audio_left;
        m_buf_r = audio_if.i_audio_right;
      end else if (fs) begin
        m_full = 1'b0;
      end
      m_prev   = lrclk;
      last_fs  = fs;
      last_rs  = rs;
      last_acc = acc;
    end
    @(posedge bclk);
    #1;
    tests++;
    if (sdata_out !== exp_sdata) begin
      fails++;
      $display("[TB] FAIL %s sdata_out: got %b, expected %b (t=%0t)", cur_test, sdata_out, exp_sdata, $time);
    end
    tests++;
    if (o_underrun !== exp_under) begin
      fails++;
      $display("[TB] FAIL %s o_underrun: got %b, expected %b (t=%0t)", cur_test, o_underrun, exp_under, $time);
    end
    tests++;
    if (audio_if.o_audio_ready !== !m_full) begin
      fails++;
      $display("[TB] FAIL %s o_audio_ready: got %b, expected %b (t=%0t)", cur_test, audio_if.o_audio_ready, !m_full, $time);
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * SW; i++) begin
      tick();
      if (last_fs) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * SW; i++) begin
      tick();
      if (last_rs) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Deserialise DW bits starting with the bit already on sdata_out.
  task automatic capture_word(output logic [DW-1:0] w);
    w = '0;
    w[0] = sdata_out;
    for (int i = 1; i < DW; i++) begin
      tick();
      w = {w[DW-2:0], sdata_out};
    end
  endtask

  task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r, output bit ok);
    audio_if.i_audio_left  = l;
    audio_if.i_audio_right = r;
    audio_if.i_audio_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4 * SW; i++) begin
      tick();
      if (last_acc) begin
        ok = 1'b1;
        break;
      end
    end
    audio_if.i_audio_valid = 1'b0;
  endtask

  task automatic test_reset();
    int nz;
    cur_test = "reset";
    phase = SW;
    reset = 1'b1;
    repeat (5) tick();
    tests++;
    if (sdata_out !== 1'b0 || o_underrun !== 1'b0 || audio_if.o_audio_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_values: got sdata=%b underrun=%b ready=%b, expected 0 0 1", sdata_out, o_underrun, audio_if.o_audio_ready);
    end
    reset = 1'b0;
    nz = 0;
    while ((phase % (2 * SW)) != (2 * SW - 4)) begin
      tick();
      if (sdata_out !== 1'b0) nz++;
    end
    tests++;
    if (nz != 0) begin
      fails++;
      $display("[TB] FAIL first_right_slot: got %0d nonzero bits, expected 0", nz);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [DW-1:0] w;
    cur_test = "basic";
    offer(24'hACE123, 24'h5A5A5A, ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL basic_accept: got no acceptance, expected accept"); end
    wait_fs(ok);
    capture_word(w);
    tests++;
    if (!ok || w !== 24'hACE123) begin
      fails++;
      $display("[TB] FAIL basic_left: got %h (edge %b), expected ace123", w, ok);
    end
    wait_rs(ok);
    capture_word(w);
    tests++;
    if (!ok || w !== 24'h5A5A5A) begin
      fails++;
      $display("[TB] FAIL basic_right: got %h (edge %b), expected 5a5a5a", w, ok);
    end
  endtask

  task automatic test_underrun();
    bit ok, p0;
    logic [DW-1:0] w, exp_l, exp_r;
    cur_test = "underrun";
    exp_l = REPEAT ? 24'hACE123 : '0;
    exp_r = REPEAT ? 24'h5A5A5A : '0;
    wait_fs(ok);
    p0 = o_underrun;
    capture_word(w);
    tests++;
    if (!ok || p0 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL underrun_pulse: got %b (edge %b), expected 1", p0, ok);
    end
    tests++;
    if (w !== exp_l) begin
      fails++;
      $display("[TB] FAIL underrun_left: got %h, expected %h", w, exp_l);
    end
    wait_rs(ok);
    capture_word(w);
    tests++;
    if (!ok || w !== exp_r) begin
      fails++;
      $display("[TB] FAIL underrun_right: got %h, expected %h", w, exp_r);
    end
  endtask

  task automatic test_same_cycle();
    bit ok, fs_hit;
    logic [DW-1:0] w;
    cur_test = "same_cycle";
    while ((phase % (2 * SW)) != 0) tick();
    audio_if.i_audio_left  = 24'h800001;
    audio_if.i_audio_right = 24'h7FFFFF;
    audio_if.i_audio_valid = 1'b1;
    tick();
    fs_hit = last_fs;
    audio_if.i_audio_valid = 1'b0;
    tests++;
    if (!fs_hit || o_underrun !== 1'b1 || audio_if.o_audio_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL same_cycle_edge: got fs=%b underrun=%b ready=%b, expected 1 1 0", fs_hit, o_underrun, audio_if.o_audio_ready);
    end
    wait_fs(ok);
    capture_word(w);
    tests++;
    if (!ok || w !== 24'h800001) begin
      fails++;
      $display("[TB] FAIL same_cycle_left: got %h, expected 800001", w);
    end
    wait_rs(ok);
    capture_word(w);
    tests++;
    if (!ok || w !== 24'h7FFFFF) begin
      fails++;
      $display("[TB] FAIL same_cycle_right: got %h, expected 7fffff", w);
    end
  endtask

  task automatic test_full();
    bit ok;
    int took;
    logic [DW-1:0] a_l, a_r, w;
    cur_test = "full";
    a_l = DW'($urandom);
    a_r = DW'($urandom);
    offer(a_l, a_r, ok);
    audio_if.i_audio_left  = DW'($urandom);
    audio_if.i_audio_right = DW'($urandom);
    audio_if.i_audio_valid = 1'b1;
    took = 0;
    repeat (5) begin
      tick();
      if (last_acc) took++;
    end
    audio_if.i_audio_valid = 1'b0;
    tests++;
    if (!ok || took != 0 || audio_if.o_audio_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL full_blocked: got first=%b second_taken=%0d ready=%b, expected 1 0 0", ok, took, audio_if.o_audio_ready);
    end
    wait_fs(ok);
    tests++;
    if (!ok || audio_if.o_audio_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL full_ready_back: got %b, expected 1", audio_if.o_audio_ready);
    end
    capture_word(w);
    tests++;
    if (w !== a_l) begin
      fails++;
      $display("[TB] FAIL full_left: got %h, expected %h", w, a_l);
    end
    wait_rs(ok);
    capture_word(w);
    tests++;
    if (!ok || w !== a_r) begin
      fails++;
      $display("[TB] FAIL full_right: got %h, expected %h", w, a_r);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, p0;
    logic [DW-1:0] e_l, e_r, w;
    cur_test = "reset_mid";
    wait_fs(ok);
    repeat (9) tick();
    offer(DW'($urandom), DW'($urandom), ok);
    reset = 1'b1;
    tick();
    tests++;
    if (sdata_out !== 1'b0 || audio_if.o_audio_ready !== 1'b1 || o_underrun !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_values: got sdata=%b ready=%b underrun=%b, expected 0 1 0", sdata_out, audio_if.o_audio_ready, o_underrun);
    end
    reset = 1'b0;
    wait_fs(ok);
    p0 = o_underrun;
    capture_word(w);
    tests++;
    if (!ok || p0 !== 1'b1 || w !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid_discard: got underrun=%b left=%h, expected 1 000000", p0, w);
    end
    e_l = DW'($urandom);
    e_r = DW'($urandom);
    offer(e_l, e_r, ok);
    wait_fs(ok);
    capture_word(w);
    tests++;
    if (!ok || w !== e_l) begin
      fails++;
      $display("[TB] FAIL reset_mid_resume: got %h, expected %h", w, e_l);
    end
  endtask

  task automatic test_random();
    cur_test = "random";
    for (int i = 0; i < 700; i++) begin
      if (i == 150 || i == 420) phase = (phase / SW + 1) * SW;
      if (!audio_if.i_audio_valid && $urandom_range(0, 29) == 0) begin
        audio_if.i_audio_left  = DW'($urandom);
        audio_if.i_audio_right = DW'($urandom);
        audio_if.i_audio_valid = 1'b1;
      end
      tick();
      if (last_acc) audio_if.i_audio_valid = 1'b0;
    end
    audio_if.i_audio_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    lrclk = 1'b1;
    audio_if.i_audio_left  = '0;
    audio_if.i_audio_right = '0;
    audio_if.i_audio_valid = 1'b0;
    test_reset();
    test_basic();
    test_underrun();
    test_same_cycle();
    test_full();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
